// File: rtl/apx_float_adder_initiator.sv
// apx_float_adder_initiator: sends operand A then B to a stb/ack float operator, collects Z,
// returns it upstream with {nan,inf,zero} flags; a per-phase watchdog locks into HUNG on a stall.
module apx_float_adder_initiator #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [31:0]      op_a,
  output logic             op_a_stb,
  input  logic             op_a_ack,
  output logic [31:0]      op_b,
  output logic             op_b_stb,
  input  logic             op_b_ack,
  input  logic [31:0]      op_z,
  input  logic             op_z_stb,
  output logic             op_z_ack,
  output logic [31:0]      rsp_z,
  output logic [2:0]       rsp_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             hung,
  output logic [CNT_W-1:0] txn_count
);
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP, HUNG} state_t;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] a_q, b_q, z_q;
  logic [2:0] flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic cmd_ready_q, a_stb_q, b_stb_q, z_ack_q, rsp_valid_q, hung_q;
  logic wd_exp;
  function automatic logic [2:0] classify(input logic [31:0] z);
    return {&z[30:23] && |z[22:0], &z[30:23] && ~|z[22:0], ~|z[30:0]};
  endfunction
  assign wd_exp = wd_q == WD_LAST;
  // A handshake is checked before the watchdog so a transfer on the expiry edge still wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = cmd_valid ? SEND_A : IDLE;
      SEND_A:  state_d = op_a_ack ? SEND_B : wd_exp ? HUNG : SEND_A;
      SEND_B:  state_d = op_b_ack ? WAIT_Z : wd_exp ? HUNG : SEND_B;
      WAIT_Z:  state_d = op_z_stb ? RESP : wd_exp ? HUNG : WAIT_Z;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = HUNG;
    endcase
    wd_d = (state_d != state_q || state_q == IDLE || state_q == RESP || state_q == HUNG) ? '0 : wd_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      hung_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      cmd_ready_q <= state_d == IDLE;
      a_stb_q     <= state_d == SEND_A;
      b_stb_q     <= state_d == SEND_B;
      z_ack_q     <= state_d == WAIT_Z;
      rsp_valid_q <= state_d == RESP;
      hung_q      <= state_d == HUNG;
      if (state_q == IDLE && cmd_valid) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      if (state_q == WAIT_Z && op_z_stb) begin
        z_q     <= op_z;
        flags_q <= classify(op_z);
      end
      if (state_q == RESP && rsp_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign op_a      = a_q;
  assign op_a_stb  = a_stb_q;
  assign op_b      = b_q;
  assign op_b_stb  = b_stb_q;
  assign op_z_ack  = z_ack_q;
  assign rsp_z     = z_q;
  assign rsp_flags = flags_q;
  assign rsp_valid = rsp_valid_q;
  assign hung      = hung_q;
  assign txn_count = cnt_q;
endmodule

// File: tb/tb_apx_float_adder_initiator.sv
// tb_apx_float_adder_initiator: scoreboard bench; main instance exercises data path and flags,
// a second TIMEOUT=8 instance exercises the long upstream stall and the watchdog hang.
module tb_apx_float_adder_initiator;
  typedef struct {
    logic [31:0] a, b, z;
    logic [2:0]  f;
    bit          lat;
  } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [31:0] cmd_a = 0, cmd_b = 0, op_a, op_b, op_z = 0, rsp_z;
  logic cmd_valid = 0, cmd_ready, op_a_stb, op_a_ack = 0, op_b_stb, op_b_ack = 0;
  logic op_z_stb = 0, op_z_ack, rsp_valid, rsp_ready = 0, hung;
  logic [2:0] rsp_flags;
  logic [1:0] txn_count;
  logic [31:0] h_op_a, h_op_b, h_rsp_z;
  logic h_cmd_valid = 0, h_cmd_ready, h_op_a_stb, h_op_b_stb, h_op_b_ack = 0, h_op_z_ack;
  logic h_rsp_valid, h_rsp_ready = 0, h_hung;
  logic [2:0] h_rsp_flags;
  logic [15:0] h_txn_count;
  int checks = 0, failures = 0;
  int da = 0, db = 0, dz = 0, rd = 0;
  logic [31:0] zval = 0;
  bit spur = 0;
  exp_t sb[$];
  apx_float_adder_initiator #(.TIMEOUT(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op_a(op_a), .op_a_stb(op_a_stb), .op_a_ack(op_a_ack), .op_b(op_b), .op_b_stb(op_b_stb),
    .op_b_ack(op_b_ack), .op_z(op_z), .op_z_stb(op_z_stb), .op_z_ack(op_z_ack), .rsp_z(rsp_z),
    .rsp_flags(rsp_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .hung(hung), .txn_count(txn_count));
  apx_float_adder_initiator #(.TIMEOUT(8)) dut_h (
    .clk(clk), .rst(rst), .cmd_a(32'h3F800000), .cmd_b(32'h40000000), .cmd_valid(h_cmd_valid),
    .cmd_ready(h_cmd_ready), .op_a(h_op_a), .op_a_stb(h_op_a_stb), .op_a_ack(1'b1), .op_b(h_op_b),
    .op_b_stb(h_op_b_stb), .op_b_ack(h_op_b_ack), .op_z(32'h40400000), .op_z_stb(1'b1),
    .op_z_ack(h_op_z_ack), .rsp_z(h_rsp_z), .rsp_flags(h_rsp_flags), .rsp_valid(h_rsp_valid),
    .rsp_ready(h_rsp_ready), .hung(h_hung), .txn_count(h_txn_count));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // Responder: counts cycles a strobe/ack has been up and answers after the programmed delay.
  initial begin
    int wa = 0, wb = 0, wz = 0, wr = 0;
    forever begin
      @(posedge clk); #1;
      wa = op_a_stb ? wa + 1 : 0;
      op_a_ack = op_a_stb && wa > da;
      wb = op_b_stb ? wb + 1 : 0;
      op_b_ack = op_b_stb && wb > db;
      wz = op_z_ack ? wz + 1 : 0;
      op_z_stb = op_z_ack ? (wz > dz) : spur;
      op_z = op_z_ack ? zval : 32'hDEADBEEF;
      wr = rsp_valid ? wr + 1 : 0;
      rsp_ready = rsp_valid && wr > rd;
    end
  end
  initial begin
    int cyc = 0, t_acc = 0, na = 0, nb = 0, nz = 0;
    logic [1:0] mcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        na = 0; nb = 0; nz = 0; mcnt = 0;
      end else begin
        if (cmd_valid && cmd_ready) t_acc = cyc;
        if (op_a_stb || op_b_stb) chk("one_strobe", 32'(op_a_stb & op_b_stb), 0);
        if (op_a_stb && sb.size() > 0) chk("op_a_stable", op_a, sb[0].a);
        if (op_b_stb && sb.size() > 0) chk("op_b_stable", op_b, sb[0].b);
        if (op_a_stb && op_a_ack) na++;
        if (op_b_stb && op_b_ack) begin
          chk("a_before_b", 32'(na), 1);
          nb++;
        end
        if (op_z_stb && op_z_ack) nz++;
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_z", rsp_z, e.z);
            chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
            chk("a_xfers", 32'(na), 1);
            chk("b_xfers", 32'(nb), 1);
            chk("z_xfers", 32'(nz), 1);
            chk("txn_count_pre", 32'(txn_count), 32'(mcnt));
            if (e.lat) chk("overhead_cycles", 32'(cyc - t_acc + 1), 5);
          end
          mcnt++;
          na = 0; nb = 0; nz = 0;
        end
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input logic [2:0] f,
                     input int pa, input int pb, input int pz, input bit lat, input bit sp);
    int n = 0;
    da = pa; db = pb; dz = pz; zval = z; spur = sp;
    sb.push_back('{a: a, b: b, z: z, f: f, lat: lat});
    issue(a, b);
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("txn_done", 32'(sb.size()), 0);
    spur = 0;
  endtask
  initial begin
    int n = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_a_stb", 32'(op_a_stb), 0);
    chk("rst_b_stb", 32'(op_b_stb), 0);
    chk("rst_z_ack", 32'(op_z_ack), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_hung", 32'(hung), 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_flags", 32'(rsp_flags), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    @(posedge clk); #1;
    h_op_b_ack = 1;
    h_cmd_valid = 1;
    @(posedge clk); #1;
    h_cmd_valid = 0;
    repeat (2000) @(posedge clk);
    #1;
    chk("h_stall_no_hang", 32'(h_hung), 0);
    chk("h_stall_rsp_valid", 32'(h_rsp_valid), 1);
    chk("h_stall_rsp_z", h_rsp_z, 32'h40400000);
    h_rsp_ready = 1;
    @(posedge clk); #1;
    h_rsp_ready = 0;
    chk("h_txn_count", 32'(h_txn_count), 1);
    chk("h_cmd_ready", 32'(h_cmd_ready), 1);
    h_op_b_ack = 0;
    h_cmd_valid = 1;
    @(posedge clk); #1;
    h_cmd_valid = 0;
    while (!h_op_b_stb && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("h_b_entry", 32'(h_op_b_stb), 1);
    repeat (7) @(posedge clk);
    #1 chk("h_hung_before", 32'(h_hung), 0);
    @(posedge clk);
    #1 chk("h_hung_at_8", 32'(h_hung), 1);
    chk("h_hung_cmd_ready", 32'(h_cmd_ready), 0);
    chk("h_hung_b_stb", 32'(h_op_b_stb), 0);
    h_op_b_ack = 1;
    repeat (20) @(posedge clk);
    #1 chk("h_hung_sticky", 32'(h_hung), 1);
    chk("h_hung_strobes", 32'({h_op_a_stb, h_op_b_stb, h_op_z_ack, h_rsp_valid, h_cmd_ready}), 0);
    txn(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 0, 0, 0, 1, 0);
    chk("txn_count_1", 32'(txn_count), 1);
    txn(32'h40A00000, 32'hC0400000, 32'h40000000, 3'b000, 7, 3, 12, 0, 0);
    txn(32'h11111111, 32'h22222222, 32'h7FC00000, 3'b100, 0, 0, 0, 0, 1);
    txn(32'h33333333, 32'h44444444, 32'hFF800000, 3'b010, 1, 2, 3, 0, 0);
    txn(32'h55555555, 32'h66666666, 32'h80000000, 3'b001, 0, 0, 0, 0, 0);
    chk("txn_count_wrap", 32'(txn_count), 1);
    txn(32'h77777777, 32'h88888888, 32'h00000001, 3'b000, 0, 0, 0, 0, 0);
    da = 0; db = 0; dz = 40;
    sb.push_back('{a: 32'hAAAA0001, b: 32'hBBBB0002, z: 32'h0, f: 3'b000, lat: 0});
    issue(32'hAAAA0001, 32'hBBBB0002);
    n = 0;
    while (!op_z_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_wait_z", 32'(op_z_ack), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_z_ack", 32'(op_z_ack), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_op_a", op_a, 0);
    chk("mid_rst_op_b", op_b, 0);
    chk("mid_rst_txn_count", 32'(txn_count), 0);
    chk("mid_rst_h_hung", 32'(h_hung), 0);
    dz = 0;
    @(posedge clk); #1;
    txn(32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 0, 0, 0, 1, 0);
    chk("post_rst_txn_count", 32'(txn_count), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/apx_float_adder_initiator.md
# apx_float_adder_initiator

Initiator/master side of the 32-bit stb/ack operand protocol used by the approximate float operator blocks (e.g. `apx_float_adder`). It accepts an operand pair from an upstream valid/ready command port and drives `a`, then `b`, to the operator. It then collects `z` and returns it upstream with IEEE-754 class flags. A per-phase watchdog detects a stalled operator and locks the block in a hung state until reset.

## Interface
- `TIMEOUT`, default 1023: max cycles spent in any single handshake phase before declaring hang (1..65535).
- `CNT_W`, default 16: width of transaction counter.
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_a` in 32: operand A (IEEE single).
- `cmd_b` in 32: operand B.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can take a command.
- `op_a` out 32: operand A toward operator.
- `op_a_stb` out 1: A strobe.
- `op_a_ack` in 1: operator ready for A.
- `op_b` out 32: operand B toward operator.
- `op_b_stb` out 1: B strobe.
- `op_b_ack` in 1: operator ready for B.
- `op_z` in 32: result from operator.
- `op_z_stb` in 1: result strobe.
- `op_z_ack` out 1: initiator ready for result.
- `rsp_z` out 32: captured result.
- `rsp_flags` out 3: {nan, inf, zero} of `rsp_z`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: upstream takes response.
- `hung` out 1: sticky watchdog expiry.
- `txn_count` out CNT_W: completed responses, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RESP, HUNG.
- Transfer rule, every channel: a word moves on a posedge where strobe and ack are both 1; nothing else counts.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`: latch `cmd_a`/`cmd_b`, go SEND_A.
- SEND_A: `op_a_stb`=1, `op_a` = latched A held stable. On `op_a_ack` sampled 1: go SEND_B.
- SEND_B: `op_b_stb`=1, `op_b` = latched B. On `op_b_ack`: go WAIT_Z.
- WAIT_Z: `op_z_ack`=1. On `op_z_stb`: capture `op_z` into `rsp_z`, compute flags, go RESP.
- RESP: `rsp_valid`=1, `rsp_z`/`rsp_flags` stable. On `rsp_ready`: `txn_count`+1 (wrap), go IDLE.
- Flags from the captured word: nan = exp==255 && mant!=0; inf = exp==255 && mant==0; zero = exp==0 && mant==0; sign ignored. Denormals set no flag.
- Watchdog: phase counter clears on every state change. It increments each cycle in SEND_A, SEND_B and WAIT_Z. Reaching TIMEOUT goes to HUNG. It is not active in IDLE or RESP, where upstream may stall indefinitely.
- HUNG: `hung`=1. All strobes/acks 0, `cmd_ready`=0, `rsp_valid`=0. Exit only via `rst`; the system must also reset the operator.
- Strobes and acks are registered outputs, decoded from the state register only.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `op_a_stb`, `op_b_stb`, `op_z_ack`, `rsp_valid`, `hung` = 0; `op_a`, `op_b`, `rsp_z` = 0; `rsp_flags`=0; `txn_count`=0; watchdog 0.
- Reset mid-transaction: everything returns to reset values the next cycle. The in-flight command and response are dropped, with no count increment.
- Command accept at edge N: `op_a_stb`=1 in cycle N+1.
- A transfer at edge M: `op_a_stb`=0 and `op_b_stb`=1 in cycle M+1. B→WAIT_Z and Z→RESP follow the same pattern.
- Each hop costs 1 cycle. Minimum initiator overhead with a zero-wait responder is 5 cycles, command accept to response accept.
- Never two strobes asserted in the same cycle; A always precedes B.
- Stall with ack held 1 and strobe already 1: transfer on the first edge. Ack toggling while strobe is 0 has no effect.
- Spurious `op_z_stb` outside WAIT_Z is ignored.
- Timeout edge case: if the ack arrives on the same edge the counter hits TIMEOUT, the transfer wins.

## Test plan
- Zero-wait responder; cmd_a=0x3F800000, cmd_b=0x40000000; responder returns 0x40400000 -> A then B seen once each, rsp_z=0x40400000, flags=000, txn_count=1, 5-cycle overhead.
- Responder delays A ack 7 cycles, B ack 3, Z stb 12 -> `op_a`/`op_b` stable throughout the stalls, exactly one transfer per channel, rsp correct.
- Responses 0x7FC00000, 0xFF800000, 0x80000000, 0x00000001 -> flags 100, 010, 001, 000.
- TIMEOUT=8, responder never acks B -> `hung`=1 exactly 8 cycles after SEND_B entry, `cmd_ready`=0, all strobes 0 until `rst`.
- `rst` pulsed in WAIT_Z, then a new command -> outputs at reset values one cycle later, txn_count=0, the new transaction completes normally.
- Upstream holds `rsp_ready`=0 for 2000 cycles with TIMEOUT=8 -> no hang. CNT_W=2 with 5 transactions -> txn_count=1.
